// File: rtl/cam_draw_pkg.sv
// Shared constants, coordinate widths and FSM encoding for the camera line drawer.
package cam_draw_pkg;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int PEN_UP_CODE = 1023;

    localparam int CAM_W = 10;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int ERR_W = 12;
    localparam int E2_W  = ERR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCALE = 2'd1,
        SETUP = 2'd2,
        DRAW  = 2'd3
    } state_t;

    // One Bresenham position together with its error term.
    typedef struct packed {
        logic [X_W-1:0]          x;
        logic [Y_W-1:0]          y;
        logic signed [ERR_W-1:0] err;
    } step_t;

endpackage

// File: rtl/cam_scale.sv
// Combinational 1024x768 -> 640x480 scaling (x5/8) with clamp to the screen edge.
module cam_scale
    import cam_draw_pkg::*;
#(
    parameter int MAX_X = SCREEN_W - 1,
    parameter int MAX_Y = SCREEN_H - 1
) (
    input  logic [CAM_W-1:0] cam_x,
    input  logic [CAM_W-1:0] cam_y,
    output logic [X_W-1:0]   sx,
    output logic [Y_W-1:0]   sy
);

    // 1023*5 = 5115 fits in 13 unsigned bits; >>3 leaves a 10-bit quotient.
    function automatic logic [CAM_W-1:0] scale_5_8(input logic [CAM_W-1:0] v);
        logic [12:0] prod;
        prod = 13'(v) * 13'd5;
        return prod[12:3];
    endfunction

    function automatic logic [X_W-1:0] sat_x(input logic [CAM_W-1:0] v);
        return (v > CAM_W'(MAX_X)) ? X_W'(MAX_X) : X_W'(v);
    endfunction

    function automatic logic [Y_W-1:0] sat_y(input logic [CAM_W-1:0] v);
        return (v > CAM_W'(MAX_Y)) ? Y_W'(MAX_Y) : v[Y_W-1:0];
    endfunction

    // Scale then clamp each axis independently.
    always_comb begin
        sx = sat_x(scale_5_8(cam_x));
        sy = sat_y(scale_5_8(cam_y));
    end

endmodule

// File: rtl/cam_line_drawer.sv
// Turns camera points into a gap-free stroke: scales each point to VGA space and
// rasterises a Bresenham line from the previous point, one pixel request per cycle.
module cam_line_drawer
    import cam_draw_pkg::*;
#(
    parameter int MAX_X       = SCREEN_W - 1,
    parameter int MAX_Y       = SCREEN_H - 1,
    parameter int PEN_UP_CODE = cam_draw_pkg::PEN_UP_CODE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CAM_W-1:0] cam_x,
    input  logic [CAM_W-1:0] cam_y,
    input  logic             cam_valid,
    output logic [X_W-1:0]   pix_x,
    output logic [Y_W-1:0]   pix_y,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             busy,
    output logic [7:0]       dropped
);

    state_t state, state_nxt;

    logic             pend_full;
    logic [CAM_W-1:0] pend_x, pend_y;
    logic [CAM_W-1:0] cap_x, cap_y;
    logic             pen_down;
    logic             single;
    logic [7:0]       drop_cnt;

    logic [X_W-1:0] scl_x, tgt_x, prev_x, cur_x;
    logic [Y_W-1:0] scl_y, tgt_y, prev_y, cur_y;

    logic signed [ERR_W-1:0] dx, dy, err;
    logic                    neg_x, neg_y;

    logic                    consume, pend_pen_up, at_end, same_pt;
    logic signed [ERR_W-1:0] diff_x, diff_y, setup_dx, setup_dy, setup_err;
    logic                    setup_neg_x, setup_neg_y;
    step_t                   first_step, next_step;

    // One Bresenham move: e2 >= dy steps x, e2 <= dx steps y (both may fire).
    function automatic step_t bres_step(
        input logic [X_W-1:0]          x,
        input logic [Y_W-1:0]          y,
        input logic signed [ERR_W-1:0] e,
        input logic signed [ERR_W-1:0] ddx,
        input logic signed [ERR_W-1:0] ddy,
        input logic                    nx,
        input logic                    ny
    );
        step_t                  r;
        logic signed [E2_W-1:0] e2;
        e2    = $signed({e, 1'b0});
        r.x   = x;
        r.y   = y;
        r.err = e;
        if (e2 >= E2_W'(ddy)) begin
            r.err = r.err + ddy;
            r.x   = nx ? (x - X_W'(1)) : (x + X_W'(1));
        end
        if (e2 <= E2_W'(ddx)) begin
            r.err = r.err + ddx;
            r.y   = ny ? (y - Y_W'(1)) : (y + Y_W'(1));
        end
        return r;
    endfunction

    cam_scale #(
        .MAX_X (MAX_X),
        .MAX_Y (MAX_Y)
    ) u_scale (
        .cam_x (cap_x),
        .cam_y (cap_y),
        .sx    (scl_x),
        .sy    (scl_y)
    );

    // Line setup terms and the first step from the start point, which is never redrawn.
    always_comb begin
        diff_x      = $signed(ERR_W'(tgt_x)) - $signed(ERR_W'(prev_x));
        diff_y      = $signed(ERR_W'(tgt_y)) - $signed(ERR_W'(prev_y));
        setup_neg_x = diff_x < 0;
        setup_neg_y = diff_y < 0;
        setup_dx    = setup_neg_x ? -diff_x : diff_x;
        setup_dy    = setup_neg_y ? diff_y : -diff_y;
        setup_err   = setup_dx + setup_dy;
        same_pt     = (tgt_x == prev_x) && (tgt_y == prev_y);
        first_step  = bres_step(prev_x, prev_y, setup_err, setup_dx, setup_dy,
                                setup_neg_x, setup_neg_y);
        next_step   = bres_step(cur_x, cur_y, err, dx, dy, neg_x, neg_y);
    end

    // Next-state logic and slot consumption.
    always_comb begin
        state_nxt   = state;
        consume     = 1'b0;
        pend_pen_up = (pend_x == CAM_W'(PEN_UP_CODE)) && (pend_y == CAM_W'(PEN_UP_CODE));
        at_end      = single || ((cur_x == tgt_x) && (cur_y == tgt_y));
        case (state)
            IDLE: begin
                if (pend_full) begin
                    consume   = 1'b1;
                    state_nxt = pend_pen_up ? IDLE : SCALE;
                end
            end
            SCALE:   state_nxt = pen_down ? SETUP : DRAW;
            SETUP:   state_nxt = same_pt ? IDLE : DRAW;
            DRAW:    if (pix_ready && at_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: FSM, pending flag, pen, drop counter and the presented pixel.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            pend_full <= 1'b0;
            pen_down  <= 1'b0;
            single    <= 1'b0;
            drop_cnt  <= 8'd0;
            cur_x     <= '0;
            cur_y     <= '0;
        end else begin
            state <= state_nxt;
            if (cam_valid) begin
                pend_full <= 1'b1;
                if (pend_full && !consume && (drop_cnt != 8'hFF))
                    drop_cnt <= drop_cnt + 8'd1;
            end else if (consume) begin
                pend_full <= 1'b0;
            end
            case (state)
                IDLE: if (consume && pend_pen_up) pen_down <= 1'b0;
                SCALE: begin
                    single <= !pen_down;
                    if (!pen_down) begin
                        pen_down <= 1'b1;
                        cur_x    <= scl_x;
                        cur_y    <= scl_y;
                    end
                end
                SETUP: begin
                    cur_x <= first_step.x;
                    cur_y <= first_step.y;
                end
                DRAW: begin
                    if (pix_ready && !at_end) begin
                        cur_x <= next_step.x;
                        cur_y <= next_step.y;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers: sample slot, target, previous point and Bresenham terms.
    always_ff @(posedge clk) begin
        if (cam_valid) begin
            pend_x <= cam_x;
            pend_y <= cam_y;
        end
        case (state)
            IDLE: begin
                if (consume) begin
                    cap_x <= pend_x;
                    cap_y <= pend_y;
                end
            end
            SCALE: begin
                tgt_x <= scl_x;
                tgt_y <= scl_y;
                if (!pen_down) begin
                    prev_x <= scl_x;
                    prev_y <= scl_y;
                end
            end
            SETUP: begin
                dx    <= setup_dx;
                dy    <= setup_dy;
                neg_x <= setup_neg_x;
                neg_y <= setup_neg_y;
                err   <= first_step.err;
            end
            DRAW: begin
                if (pix_ready) begin
                    if (at_end) begin
                        prev_x <= tgt_x;
                        prev_y <= tgt_y;
                    end else begin
                        err <= next_step.err;
                    end
                end
            end
            default: ;
        endcase
    end

    assign pix_x     = cur_x;
    assign pix_y     = cur_y;
    assign pix_valid = (state == DRAW);
    assign busy      = (state != IDLE);
    assign dropped   = drop_cnt;

endmodule

// File: tb/tb_cam_line_drawer.sv
// Directed bench for cam_line_drawer with a pixel scoreboard and handshake-stability checks.
module tb_cam_line_drawer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] cam_x, cam_y;
    logic       cam_valid;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic       pix_valid;
    logic       pix_ready;
    logic       busy;
    logic [7:0] dropped;

    int n_cmp = 0;
    int n_err = 0;
    int q[$];
    int acc = 0;
    int last_x = -1, last_y = -1;
    bit held = 0;
    int hx = 0, hy = 0;
    bit ready_mode = 0;
    int phase = 0;

    cam_line_drawer dut (
        .clk       (clk),
        .reset     (reset),
        .cam_x     (cam_x),
        .cam_y     (cam_y),
        .cam_valid (cam_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .busy      (busy),
        .dropped   (dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void push_pt(input int x, input int y);
        q.push_back(x * 1024 + y);
    endfunction

    // Reference rasteriser: start point excluded, end point included.
    function automatic void push_line(input int x0, input int y0, input int x1, input int y1);
        int ddx, ddy, stx, sty, e, e2, x, y;
        ddx = (x1 > x0) ? x1 - x0 : x0 - x1;
        ddy = (y1 > y0) ? y0 - y1 : y1 - y0;
        stx = (x0 < x1) ? 1 : -1;
        sty = (y0 < y1) ? 1 : -1;
        e = ddx + ddy;
        x = x0;
        y = y0;
        while (!(x == x1 && y == y1)) begin
            e2 = 2 * e;
            if (e2 >= ddy) begin e += ddy; x += stx; end
            if (e2 <= ddx) begin e += ddx; y += sty; end
            push_pt(x, y);
        end
    endfunction

    // One clock: observe the handshake at the falling edge, then drive after the rising edge.
    task automatic step_cycle();
        @(negedge clk);
        if (held) begin
            check("hold_valid", int'(pix_valid), 1);
            check("hold_x", int'(pix_x), hx);
            check("hold_y", int'(pix_y), hy);
        end
        held = 0;
        if (pix_valid && !pix_ready) begin
            held = 1;
            hx = int'(pix_x);
            hy = int'(pix_y);
        end
        if (pix_valid && pix_ready) begin
            check("pix_expected", int'(q.size() != 0), 1);
            if (q.size() != 0) check("pix_xy", int'(pix_x) * 1024 + int'(pix_y), q.pop_front());
            acc++;
            last_x = int'(pix_x);
            last_y = int'(pix_y);
        end
        @(posedge clk);
        #1;
        if (ready_mode) begin
            pix_ready = (phase % 3 == 0);
            phase++;
        end
    endtask

    task automatic send(input int x, input int y);
        cam_x = 10'(x);
        cam_y = 10'(y);
        cam_valid = 1'b1;
        step_cycle();
        cam_valid = 1'b0;
    endtask

    task automatic latency(input int expl);
        int lat = 0;
        while (!pix_valid && lat < 10) begin
            step_cycle();
            lat++;
        end
        check("latency", lat, expl);
    endtask

    task automatic drain(input int maxc);
        int c = 0;
        while ((q.size() != 0 || busy) && c < maxc) begin
            step_cycle();
            c++;
        end
        check("drain_in_time", int'(c < maxc), 1);
        check("busy_idle", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int guard;
        reset = 1'b0;
        cam_x = '0;
        cam_y = '0;
        cam_valid = 1'b0;
        pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_x", int'(pix_x), 0);
        check("rst_pix_y", int'(pix_y), 0);
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_dropped", int'(dropped), 0);
        reset = 1'b1;
        step_cycle();

        // First point after reset: pen is up, so a single pixel.
        acc = 0;
        push_pt(0, 0);
        send(0, 0);
        latency(2);
        drain(20);
        check("first_count", acc, 1);

        // Line (0,0) -> (10,5) at full throughput.
        acc = 0;
        push_line(0, 0, 10, 5);
        send(16, 8);
        latency(3);
        drain(40);
        check("line_count", acc, 10);
        check("line_end_x", last_x, 10);
        check("line_end_y", last_y, 5);

        // Same line again with pix_ready stalling 1,0,0.
        send(1023, 1023);
        repeat (4) step_cycle();
        check("penup_idle", int'(busy), 0);
        push_pt(0, 0);
        send(0, 0);
        drain(20);
        acc = 0;
        ready_mode = 1;
        phase = 0;
        push_line(0, 0, 10, 5);
        send(16, 8);
        drain(100);
        check("stall_count", acc, 10);
        ready_mode = 0;
        pix_ready = 1'b1;

        // Pen-up then a clamped corner point: single pixel, no line from (10,5).
        acc = 0;
        send(1023, 1023);
        repeat (3) step_cycle();
        push_pt(639, 479);
        send(1023, 767);
        latency(2);
        drain(20);
        check("corner_count", acc, 1);

        // Clamped y: line (639,479) -> (500,479).
        acc = 0;
        push_line(639, 479, 500, 479);
        send(800, 900);
        drain(300);
        check("clamp_end_x", last_x, 500);
        check("clamp_end_y", last_y, 479);
        check("clamp_count", acc, 139);

        // Long line with samples arriving while busy; only the last survives.
        send(1023, 1023);
        repeat (3) step_cycle();
        push_pt(0, 0);
        send(0, 0);
        drain(20);
        base = acc;
        push_line(0, 0, 639, 0);
        send(1023, 0);
        repeat (20) step_cycle();
        send(16, 8);
        step_cycle();
        send(32, 8);
        step_cycle();
        send(48, 16);
        check("dropped_two", int'(dropped), 2);
        push_line(639, 0, 30, 10);
        guard = 0;
        while (acc < base + 639 + 5 && guard < 2000) begin
            step_cycle();
            guard++;
        end
        check("reach_second_line", int'(guard < 2000), 1);
        check("midline_valid", int'(pix_valid), 1);

        // Reset in the middle of the second line.
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_pix_valid", int'(pix_valid), 0);
        check("midrst_dropped", int'(dropped), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_pix_x", int'(pix_x), 0);
        reset = 1'b1;
        held = 0;
        q.delete();
        acc = 0;
        repeat (5) step_cycle();
        check("after_rst_quiet", acc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
